dir_input_arbiter: RTL and testbench
====================================

Name: dir_input_arbiter

Overview:
- Parametrised successor to the direction/press-handling front end.
- Merges NUM_SRC direction sources (buttons, PS/2 keys, online link); each source has 4 direction bits.
- Classifies each merged direction as a short or long press. Long up/down presses are exported as volume pulses.
- Rejects illegal turns. Buffers up to QUEUE_DEPTH pending turns, so fast tap sequences survive until the next snake move tick.

Parameters:
- NUM_SRC, 4, number of input sources.
- QUEUE_DEPTH, 4, pending-turn FIFO depth (power of 2, ≥2).
- LONG_TICKS, 50, tick_en samples held before a press counts as long (0.5 s at 100 Hz).
- UD_SHORT_ONLY, 1, 1: up/down turn only on short-press release; 0: up/down turn on press edge like left/right.
- RESET_DIR, DIR_RIGHT, dir_state after reset/clear.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush, asserted while game is idle
- dir_req  in  4*NUM_SRC  levels; source s bits [4s+3:4s] = {right,left,down,up}
- tick_en  in  1  one-cycle press-duration sample strobe
- move_tick  in  1  one-cycle pulse; snake advances, consumes one turn
- dir_state  out  2  current committed direction
- queue_count  out  $clog2(QUEUE_DEPTH+1)  pending turns
- long_up  out  1  one-cycle pulse on long up press
- long_down  out  1  one-cycle pulse on long down press
- overflow  out  1  sticky; a legal turn was dropped because the queue was full

Behaviour:
- Reset (rst_n=0, async) values: dir_state=RESET_DIR; queue empty (queue_count=0); long_up=long_down=0; overflow=0; all classifier counters and synchronisers 0.
- clear=1: same values as reset, applied synchronously. clear takes priority over all events in that cycle.
- Merge: d[i] = OR over sources of bit i, then 2-flop synchroniser. Edge detection uses the registered previous value.
- Press classifier per direction, states IDLE, HELD, LONG:
  - IDLE→HELD on synced rise; counter cleared.
  - HELD: counter +1 on tick_en while held.
  - HELD, counter reaches LONG_TICKS: go to LONG; emit long pulse once (up/down only exported).
  - HELD, release: emit short pulse (1 cycle); go to IDLE.
  - LONG, release: go to IDLE with no short pulse.
  - Counter saturates at LONG_TICKS.
- Turn events:
  - left/right turn on synced rising edge.
  - up/down turn on short pulse if UD_SHORT_ONLY=1, else on rising edge.
- Latency: edge turn enqueued on the 3rd clk edge after dir_req rises. Short-release turn enqueued 3 edges after release.
- Simultaneous turn events in one cycle: priority up>down>left>right. Only one candidate is considered; the others are discarded and do not set overflow.
- Legality: ref = tail entry if queue_count>0, else dir_state (pre-cycle values).
  - Candidate equal to ref or opposite of ref is discarded.
  - Otherwise enqueue. If queue is full and no pop occurs this cycle, drop and set overflow.
- move_tick with queue_count>0: pop head; dir_state takes head value at the same edge. With queue empty, dir_state holds.
- Push and pop in the same cycle: both happen; count unchanged. Full+pop+push is legal, no overflow.
- Pointers wrap modulo QUEUE_DEPTH.

Decomposition:
- Shared package snake_pkg: DIR_UP=2'd0, DIR_DOWN=2'd1, DIR_LEFT=2'd2, DIR_RIGHT=2'd3; function dir_opposite; bit-index constants for the dir_req source layout.
- One sub-module: press_classifier (params LONG_TICKS; ports clk, rst_n, clear, held, tick_en, short_p, long_p). Instantiated 4×.

Test Plan:
- Reset: rst_n low mid-operation with 3 entries queued → immediately dir_state=3 (RIGHT), queue_count=0, overflow=0.
- Source 2 raises left (bit 10) while dir_state=RIGHT → rejected, queue_count stays 0. Source 0 raises up, tap lasting 5 tick_en → after release +3 cycles queue_count=1; move_tick → dir_state=0 (UP).
- Up held 60 tick_en → long_up pulses exactly once at tick 50; release gives no turn, queue_count=0.
- Taps up,left,down,right,up with no move_tick, QUEUE_DEPTH=4 → first four accepted, fifth sets overflow=1. Four move_ticks → dir_state sequence 0,2,1,3.
- Up and left rise in the same cycle, UD_SHORT_ONLY=0, dir_state=RIGHT → only UP enqueued.
- Queue full, move_tick coincident with a legal enqueue → queue_count stays 4, overflow=0. Then clear=1 → queue_count=0, dir_state=3.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared direction encoding, dir_req bit layout and press-classifier state type
// for the snake direction front end.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  // Per-source bit positions inside each 4-bit dir_req slice.
  localparam int BIT_UP       = 0;
  localparam int BIT_DOWN     = 1;
  localparam int BIT_LEFT     = 2;
  localparam int BIT_RIGHT    = 3;
  localparam int BITS_PER_SRC = 4;

  typedef enum logic [1:0] {
    PRESS_IDLE = 2'd0,
    PRESS_HELD = 2'd1,
    PRESS_LONG = 2'd2
  } press_state_e;

  // The encoding pairs opposites as {0,1} and {2,3}.
  function automatic logic [1:0] dir_opposite(input logic [1:0] dir);
    return dir ^ 2'b01;
  endfunction

endpackage

// File: rtl/press_classifier.sv
// Short/long press classifier for one synchronised direction level.
// state      | meaning
// PRESS_IDLE | not held
// PRESS_HELD | held, remain counts down tick_en samples to the long threshold
// PRESS_LONG | long press already reported, waiting for release
module press_classifier
  import snake_pkg::*;
#(
  parameter int LONG_TICKS = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic held,
  input  logic tick_en,
  output logic short_p,
  output logic long_p
);

  localparam int CNT_W = $clog2(LONG_TICKS + 1);

  press_state_e     state;
  logic [CNT_W-1:0] remain;

  // Decoded from state so a short release turn lands on the 3rd edge after release.
  assign short_p = (state == PRESS_HELD) && !held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= PRESS_IDLE;
      remain <= '0;
      long_p <= 1'b0;
    end else if (clear) begin
      state  <= PRESS_IDLE;
      remain <= '0;
      long_p <= 1'b0;
    end else begin
      long_p <= 1'b0;
      case (state)
        PRESS_IDLE: begin
          if (held) begin
            state  <= PRESS_HELD;
            remain <= CNT_W'(LONG_TICKS);
          end
        end
        PRESS_HELD: begin
          if (!held) begin
            state <= PRESS_IDLE;
          end else if (tick_en) begin
            if (remain == CNT_W'(1)) begin
              state  <= PRESS_LONG;
              long_p <= 1'b1;
            end
            remain <= remain - CNT_W'(1);
          end
        end
        PRESS_LONG: begin
          if (!held) state <= PRESS_IDLE;
        end
        default: state <= PRESS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/dir_input_arbiter.sv
// Merges direction sources, classifies presses, filters illegal turns and
// queues pending turns until the next snake move tick.
module dir_input_arbiter
  import snake_pkg::*;
#(
  parameter int         NUM_SRC       = 4,
  parameter int         QUEUE_DEPTH   = 4,
  parameter int         LONG_TICKS    = 50,
  parameter int         UD_SHORT_ONLY = 1,
  parameter logic [1:0] RESET_DIR     = DIR_RIGHT
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  input  logic [4*NUM_SRC-1:0]               dir_req,
  input  logic                               tick_en,
  input  logic                               move_tick,
  output logic [1:0]                         dir_state,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
  output logic                               long_up,
  output logic                               long_down,
  output logic                               overflow
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  logic [3:0]       merged, sync1, sync2, prev, rise, turn_ev;
  logic [3:0]       short_p, long_p;
  logic             unused_press;
  logic [1:0]       fifo [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [1:0]       cand, ref_dir;
  logic             cand_valid, legal, full, pop, push, drop;

  always_comb begin
    merged = '0;
    for (int s = 0; s < NUM_SRC; s++) merged |= dir_req[BITS_PER_SRC*s +: BITS_PER_SRC];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else if (clear) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= merged;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;

  for (genvar i = 0; i < 4; i++) begin : g_press
    press_classifier #(.LONG_TICKS(LONG_TICKS)) u_press (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .held    (sync2[i]),
      .tick_en (tick_en),
      .short_p (short_p[i]),
      .long_p  (long_p[i])
    );
  end

  // Left/right long pulses and (in edge mode) up/down short pulses have no consumer.
  assign unused_press = ^{short_p, long_p};
  assign long_up      = long_p[BIT_UP];
  assign long_down    = long_p[BIT_DOWN];

  assign turn_ev[BIT_UP]    = (UD_SHORT_ONLY != 0) ? short_p[BIT_UP]   : rise[BIT_UP];
  assign turn_ev[BIT_DOWN]  = (UD_SHORT_ONLY != 0) ? short_p[BIT_DOWN] : rise[BIT_DOWN];
  assign turn_ev[BIT_LEFT]  = rise[BIT_LEFT];
  assign turn_ev[BIT_RIGHT] = rise[BIT_RIGHT];

  always_comb begin
    cand_valid = 1'b1;
    cand       = DIR_UP;
    if      (turn_ev[BIT_UP])    cand = DIR_UP;
    else if (turn_ev[BIT_DOWN])  cand = DIR_DOWN;
    else if (turn_ev[BIT_LEFT])  cand = DIR_LEFT;
    else if (turn_ev[BIT_RIGHT]) cand = DIR_RIGHT;
    else                         cand_valid = 1'b0;
  end

  assign ref_dir = (queue_count != '0) ? fifo[wr_ptr - PTR_W'(1)] : dir_state;
  assign legal   = cand_valid && (cand != ref_dir) && (cand != dir_opposite(ref_dir));
  assign full    = (queue_count == CNT_W'(QUEUE_DEPTH));
  assign pop     = move_tick && (queue_count != '0);
  assign push    = legal && (!full || pop);
  assign drop    = legal && full && !pop;

  always_ff @(posedge clk) begin
    if (push && !clear) fifo[wr_ptr] <= cand;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_state   <= RESET_DIR;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
      overflow    <= 1'b0;
    end else if (clear) begin
      dir_state   <= RESET_DIR;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      queue_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        dir_state <= fifo[rd_ptr];
      end
      if (push && !pop)      queue_count <= queue_count + CNT_W'(1);
      else if (pop && !push) queue_count <= queue_count - CNT_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dir_input_arbiter.sv
// Directed bench: dut uses short-release up/down turns, dut_edge uses edge turns;
// both share stimulus.
module tb_dir_input_arbiter;
  import snake_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int QD      = 4;
  localparam int CW      = $clog2(QD + 1);

  logic                 clk = 1'b0;
  logic                 rst_n, clear, tick_en, move_tick;
  logic [4*NUM_SRC-1:0] dir_req;
  logic [1:0]           dir_state, e_dir_state;
  logic [CW-1:0]        queue_count, e_queue_count;
  logic                 long_up, long_down, overflow;
  logic                 e_long_up, e_long_down, e_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int up_pulses, down_pulses, pulse_tick;

  dir_input_arbiter #(.NUM_SRC(NUM_SRC), .QUEUE_DEPTH(QD), .LONG_TICKS(50),
                      .UD_SHORT_ONLY(1), .RESET_DIR(DIR_RIGHT)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .dir_req(dir_req), .tick_en(tick_en),
    .move_tick(move_tick), .dir_state(dir_state), .queue_count(queue_count),
    .long_up(long_up), .long_down(long_down), .overflow(overflow)
  );

  dir_input_arbiter #(.NUM_SRC(NUM_SRC), .QUEUE_DEPTH(QD), .LONG_TICKS(50),
                      .UD_SHORT_ONLY(0), .RESET_DIR(DIR_RIGHT)) dut_edge (
    .clk(clk), .rst_n(rst_n), .clear(clear), .dir_req(dir_req), .tick_en(tick_en),
    .move_tick(move_tick), .dir_state(e_dir_state), .queue_count(e_queue_count),
    .long_up(e_long_up), .long_down(e_long_down), .overflow(e_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic pop_once();
    move_tick = 1'b1;
    step(1);
    move_tick = 1'b0;
  endtask

  // Short tap: long enough to reach HELD, released well before the long threshold.
  task automatic tap(input int idx);
    dir_req[idx] = 1'b1;
    step(3);
    dir_req[idx] = 1'b0;
    step(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; tick_en = 1'b0; move_tick = 1'b0; dir_req = '0;
    step(2);
    check_val("reset_dir", dir_state, 3);
    check_val("reset_count", queue_count, 0);
    check_val("reset_ovf", overflow, 0);
    check_val("reset_long", {long_up, long_down}, 0);
    rst_n = 1'b1;
    step(1);

    // Left while heading right is a reversal.
    dir_req[10] = 1'b1;
    step(3);
    check_val("left_reject", queue_count, 0);
    check_val("left_reject_edge", e_queue_count, 0);
    dir_req[10] = 1'b0;
    step(3);

    // Up tap over five tick_en samples, turn appears 3 edges after release.
    dir_req[0] = 1'b1;
    step(2);
    for (int t = 0; t < 5; t++) begin
      tick_en = 1'b1; step(1); tick_en = 1'b0; step(1);
    end
    dir_req[0] = 1'b0;
    step(2);
    check_val("short_not_yet", queue_count, 0);
    step(1);
    check_val("short_enq", queue_count, 1);
    pop_once();
    check_val("short_pop_dir", dir_state, 0);
    check_val("short_pop_count", queue_count, 0);

    // Long up press: a single long_up pulse right after the 50th sample, no turn.
    do_clear();
    up_pulses = 0; down_pulses = 0; pulse_tick = -1;
    dir_req[0] = 1'b1;
    step(3);
    for (int t = 1; t <= 60; t++) begin
      tick_en = 1'b1; step(1); tick_en = 1'b0;
      if (long_up) begin up_pulses++; pulse_tick = t; end
      if (long_down) down_pulses++;
      step(1);
      if (long_up) up_pulses++;
      if (long_down) down_pulses++;
    end
    dir_req[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1);
      if (long_up) up_pulses++;
    end
    check_val("long_up_pulses", up_pulses, 1);
    check_val("long_up_tick", pulse_tick, 50);
    check_val("long_down_pulses", down_pulses, 0);
    check_val("long_no_turn", queue_count, 0);

    // Five legal taps with no move tick: fifth overflows.
    do_clear();
    tap(0);  tap(6);  tap(9);  tap(15);
    check_val("fill_count", queue_count, 4);
    check_val("fill_ovf", overflow, 0);
    tap(4);
    check_val("ovf_count", queue_count, 4);
    check_val("ovf_set", overflow, 1);
    pop_once(); check_val("seq0", dir_state, 0);
    pop_once(); check_val("seq1", dir_state, 2);
    pop_once(); check_val("seq2", dir_state, 1);
    pop_once(); check_val("seq3", dir_state, 3);
    check_val("drained", queue_count, 0);

    // Asynchronous reset with three queued turns and overflow still set.
    tap(0); tap(2); tap(1);
    check_val("pre_reset_count", queue_count, 3);
    rst_n = 1'b0;
    #1;
    check_val("async_dir", dir_state, 3);
    check_val("async_count", queue_count, 0);
    check_val("async_ovf", overflow, 0);
    #3;
    rst_n = 1'b1;
    step(2);

    // Up and left rise together.
    do_clear();
    dir_req[4]  = 1'b1;
    dir_req[14] = 1'b1;
    step(3);
    check_val("simul_edge_count", e_queue_count, 1);
    check_val("simul_short_count", queue_count, 0);
    dir_req[4]  = 1'b0;
    dir_req[14] = 1'b0;
    step(3);
    check_val("simul_short_rel", queue_count, 1);
    check_val("simul_edge_rel", e_queue_count, 1);
    pop_once();
    check_val("simul_edge_dir", e_dir_state, 0);
    check_val("simul_short_dir", dir_state, 0);

    // Full queue, pop coincident with a legal push.
    do_clear();
    tap(0); tap(6); tap(9); tap(15);
    check_val("full_count", queue_count, 4);
    dir_req[12] = 1'b1;
    step(3);
    dir_req[12] = 1'b0;
    step(2);
    move_tick = 1'b1;
    step(1);
    move_tick = 1'b0;
    check_val("pushpop_count", queue_count, 4);
    check_val("pushpop_ovf", overflow, 0);
    check_val("pushpop_dir", dir_state, 0);
    pop_once();
    check_val("pushpop_next", dir_state, 2);
    do_clear();
    check_val("clear_count", queue_count, 0);
    check_val("clear_dir", dir_state, 3);
    check_val("clear_ovf", overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
